// File: rtl/output_device_bank_pkg.sv
// Shared constants and register-select type for the memory-mapped output device bank.
// The MODE and PULSE_LEN registers sit directly after the channel data registers.
package output_device_bank_pkg;

    localparam int PULSE_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DATA,
        REG_MODE,
        REG_PULSE_LEN
    } reg_sel_e;

    function automatic int mode_offset(input int num_devices);
        return num_devices;
    endfunction

    function automatic int pulse_len_offset(input int num_devices);
        return num_devices + 1;
    endfunction

endpackage

// File: rtl/output_device_bank_output_channel.sv
// One output channel: a data register plus a down-counter that clears the data
// when a pulse expires.
module output_channel
    import output_device_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data,
    input  logic                       pulse_en,
    input  logic [PULSE_CNT_WIDTH-1:0] pulse_len,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       busy
);

    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [PULSE_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // An expiring pulse clears the channel even if pulse mode is dropped on the
    // same edge, so a pulse value is never visible for more than its length.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            data_d = data;
            cnt_d  = pulse_en ? pulse_len : '0;
        end else if (cnt_q == PULSE_CNT_WIDTH'(1)) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (!pulse_en) begin
            cnt_d  = '0;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - PULSE_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_out = data_q;
    assign busy     = (cnt_q != '0);

endmodule

// File: rtl/output_device_bank.sv
// Bank of memory-mapped output channels with MODE/PULSE_LEN control registers
// and a registered readback path.
module output_device_bank
    import output_device_bank_pkg::*;
#(
    parameter int NUM_DEVICES = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int BASE_ADDR   = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             address,
    input  logic [DATA_WIDTH-1:0]             value,
    input  logic                              is_write,
    input  logic                              is_read,
    output logic [DATA_WIDTH-1:0]             read_value,
    output logic                              read_valid,
    output logic [NUM_DEVICES*DATA_WIDTH-1:0] device_values,
    output logic [NUM_DEVICES-1:0]            busy
);

    localparam int MODE_OFF = mode_offset(NUM_DEVICES);
    localparam int PLEN_OFF = pulse_len_offset(NUM_DEVICES);

    logic [ADDR_WIDTH:0]        offset_ext;
    logic [ADDR_WIDTH-1:0]      offset;
    reg_sel_e                   sel;
    logic [NUM_DEVICES-1:0]     chan_wr;

    logic [NUM_DEVICES-1:0]     mode_q, mode_d;
    logic [PULSE_CNT_WIDTH-1:0] pulse_len_q, pulse_len_d;
    logic [DATA_WIDTH-1:0]      read_value_q, read_value_d;
    logic                       read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic [DATA_WIDTH-1:0]      ch_data [NUM_DEVICES];

    // The extra top bit flags addresses below BASE_ADDR as a borrow.
    assign offset_ext = {1'b0, address} - {1'b0, ADDR_WIDTH'(BASE_ADDR)};
    assign offset     = offset_ext[ADDR_WIDTH-1:0];

    always_comb begin
        sel = REG_NONE;
        if (!offset_ext[ADDR_WIDTH]) begin
            if (offset < ADDR_WIDTH'(NUM_DEVICES)) begin
                sel = REG_DATA;
            end else if (offset == ADDR_WIDTH'(MODE_OFF)) begin
                sel = REG_MODE;
            end else if (offset == ADDR_WIDTH'(PLEN_OFF)) begin
                sel = REG_PULSE_LEN;
            end
        end
    end

    always_comb begin
        chan_wr = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            chan_wr[i] = is_write && (sel == REG_DATA) && (offset == ADDR_WIDTH'(i));
        end
    end

    always_comb begin
        mode_d      = mode_q;
        pulse_len_d = pulse_len_q;
        if (is_write && sel == REG_MODE) begin
            mode_d = value[NUM_DEVICES-1:0];
        end
        if (is_write && sel == REG_PULSE_LEN) begin
            pulse_len_d = value[PULSE_CNT_WIDTH-1:0];
        end
    end

    // Read mux sees pre-edge register contents, giving read-before-write ordering.
    always_comb begin
        rd_data = '0;
        case (sel)
            REG_DATA: begin
                for (int i = 0; i < NUM_DEVICES; i++) begin
                    if (offset == ADDR_WIDTH'(i)) begin
                        rd_data = ch_data[i];
                    end
                end
            end
            REG_MODE:      rd_data = DATA_WIDTH'(mode_q);
            REG_PULSE_LEN: rd_data = DATA_WIDTH'(pulse_len_q);
            default:       rd_data = '0;
        endcase
    end

    assign read_value_d = is_read ? rd_data : read_value_q;
    assign read_valid_d = is_read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= '0;
            pulse_len_q  <= '0;
            read_value_q <= '0;
            read_valid_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            pulse_len_q  <= pulse_len_d;
            read_value_q <= read_value_d;
            read_valid_q <= read_valid_d;
        end
    end

    // Channels see the post-write MODE so a cleared bit cancels the pulse on the same edge.
    generate
        for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_chan
            output_channel #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .wr_en     (chan_wr[gi]),
                .data      (value),
                .pulse_en  (mode_d[gi]),
                .pulse_len (pulse_len_q),
                .data_out  (ch_data[gi]),
                .busy      (busy[gi])
            );
            assign device_values[gi*DATA_WIDTH +: DATA_WIDTH] = ch_data[gi];
        end
    endgenerate

    assign read_value = read_value_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_output_device_bank.sv
// Self-checking bench for output_device_bank: directed scenarios followed by random
// bus traffic, compared against a deadline-based reference model.
module tb_output_device_bank;

    localparam int ND = 4;
    localparam int DW = 32;
    localparam int AW = 16;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   address;
    logic [DW-1:0]   value;
    logic            is_write;
    logic            is_read;
    logic [DW-1:0]   read_value;
    logic            read_valid;
    logic [ND*DW-1:0] device_values;
    logic [ND-1:0]   busy;

    output_device_bank #(
        .NUM_DEVICES (ND),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .value         (value),
        .is_write      (is_write),
        .is_read       (is_read),
        .read_value    (read_value),
        .read_valid    (read_valid),
        .device_values (device_values),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: each pulse is described by the edge number at which it ends.
    logic [31:0] m_val [ND];
    bit          m_pending [ND];
    longint      m_clear_at [ND];
    logic [ND-1:0] m_mode;
    logic [15:0] m_plen;
    logic [31:0] m_rv;
    logic        m_rvalid;
    longint      edge_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_val[i] = '0;
            m_pending[i] = 1'b0;
            m_clear_at[i] = 0;
        end
        m_mode = '0;
        m_plen = '0;
        m_rv = '0;
        m_rvalid = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] a);
        if (a < ND)       return m_val[a];
        if (a == ND)      return 32'(m_mode);
        if (a == ND + 1)  return 32'(m_plen);
        return 32'h0;
    endfunction

    task automatic check_all(input string ctx);
        logic [3:0] exp_busy;
        exp_busy = '0;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s ch%0d", ctx, i), device_values[i*DW +: DW], m_val[i]);
            exp_busy[i] = m_pending[i];
        end
        chk({ctx, " busy"}, 32'(busy), 32'(exp_busy));
        chk({ctx, " read_valid"}, 32'(read_valid), 32'(m_rvalid));
        chk({ctx, " read_value"}, read_value, m_rv);
    endtask

    task automatic do_cycle(input bit wr, input bit rd, input logic [15:0] a, input logic [31:0] v);
        logic [31:0] rd_exp;
        is_write = wr;
        is_read  = rd;
        address  = a;
        value    = v;
        rd_exp   = model_read(a);
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < ND; i++) begin
            if (m_pending[i] && m_clear_at[i] == edge_n) begin
                m_pending[i] = 1'b0;
                m_val[i] = '0;
            end
        end
        if (wr) begin
            if (a < ND) begin
                m_val[a] = v;
                m_pending[a] = m_mode[a] && (m_plen != 0);
                m_clear_at[a] = edge_n + longint'(m_plen);
            end else if (a == ND) begin
                m_mode = v[ND-1:0];
                for (int i = 0; i < ND; i++) if (!m_mode[i]) m_pending[i] = 1'b0;
            end else if (a == ND + 1) begin
                m_plen = v[15:0];
            end
        end
        m_rvalid = rd;
        if (rd) m_rv = rd_exp;
        #1;
        $display("[TB] edge=%0d wr=%0d rd=%0d addr=%h val=%h busy=%b rv=%h rvalid=%0d",
                 edge_n, wr, rd, a, v, busy, read_value, read_valid);
        check_all("cyc");
    endtask

    initial begin
        int n;
        int r;
        logic [15:0] ra;
        logic [31:0] rv;

        reset = 1'b1;
        address = '0;
        value = '0;
        is_write = 1'b0;
        is_read = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check_all("reset");

        // Defaults: latched writes
        do_cycle(1, 0, 16'd0, 32'hE5F84AB1);
        do_cycle(1, 0, 16'd1, 32'h5C8C6A01);
        do_cycle(0, 0, 16'd0, 32'h0);
        chk("dflt ch0", device_values[0 +: 32], 32'hE5F84AB1);
        chk("dflt ch1", device_values[32 +: 32], 32'h5C8C6A01);
        chk("dflt busy", 32'(busy), 32'h0);

        // Pulse of length 3
        do_cycle(1, 0, 16'd4, 32'h4);
        do_cycle(1, 0, 16'd5, 32'h3);
        do_cycle(1, 0, 16'd2, 32'hDEADBEEF);
        chk("pulse ch2", device_values[64 +: 32], 32'hDEADBEEF);
        n = int'(busy[2]);
        repeat (5) begin
            do_cycle(0, 0, 16'd0, 32'h0);
            n += int'(busy[2]);
        end
        chk("pulse span", 32'(n), 32'd3);
        chk("pulse cleared", device_values[64 +: 32], 32'h0);

        // Reload mid-pulse
        do_cycle(1, 0, 16'd5, 32'h5);
        do_cycle(1, 0, 16'd2, 32'hDEADBEEF);
        n = int'(busy[2]);
        do_cycle(0, 0, 16'd0, 32'h0);
        n += int'(busy[2]);
        do_cycle(1, 0, 16'd2, 32'h1);
        n += int'(busy[2]);
        chk("reload ch2", device_values[64 +: 32], 32'h1);
        repeat (8) begin
            do_cycle(0, 0, 16'd0, 32'h0);
            n += int'(busy[2]);
        end
        chk("reload span", 32'(n), 32'd7);

        // Readback
        do_cycle(0, 1, 16'd1, 32'h0);
        chk("rb ch1", read_value, 32'h5C8C6A01);
        do_cycle(0, 1, 16'(ND + 1), 32'h0);
        chk("rb plen", read_value, 32'h5);
        do_cycle(0, 1, 16'd40, 32'h0);
        chk("rb unmapped", read_value, 32'h0);
        chk("rb unmapped valid", 32'(read_valid), 32'h1);
        do_cycle(0, 0, 16'd0, 32'h0);
        chk("rb valid drop", 32'(read_valid), 32'h0);

        // Same-cycle read and write
        do_cycle(1, 1, 16'd0, 32'h0BADF00D);
        chk("rw old", read_value, 32'hE5F84AB1);
        chk("rw new", device_values[0 +: 32], 32'h0BADF00D);

        // Asynchronous reset mid-pulse
        do_cycle(1, 0, 16'd2, 32'hCAFEBABE);
        do_cycle(0, 0, 16'd0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("areset dv", device_values[31:0] | device_values[63:32] |
                         device_values[95:64] | device_values[127:96], 32'h0);
        chk("areset busy", 32'(busy), 32'h0);
        chk("areset rvalid", 32'(read_valid), 32'h0);
        chk("areset rv", read_value, 32'h0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        do_cycle(1, 0, 16'd2, 32'h12345678);
        repeat (6) do_cycle(0, 0, 16'd0, 32'h0);
        chk("post reset latched", device_values[64 +: 32], 32'h12345678);
        chk("post reset busy", 32'(busy), 32'h0);

        // Random traffic
        repeat (400) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      ra = 16'(r);
            else if (r == 6) ra = 16'd40;
            else if (r == 7) ra = 16'hFFFF;
            else begin
                rv = $urandom;
                ra = rv[15:0];
            end
            rv = $urandom;
            if (ra == 16'(ND + 1)) rv = (rv & 32'hFFFF0000) | $urandom_range(0, 6);
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
